// File: rtl/fp32_pkg.sv
// Shared single-precision constants and divider state encoding.
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam int MANT_W = FRAC_W + 1;
  localparam int REM_W = MANT_W + 2;
  localparam int ITERS = REM_W;
  localparam int CNT_W = 5;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    PACK,
    DONE
  } state_t;
endpackage

// File: rtl/float_divider_if.sv
// Operand/result bundle and start/busy/done handshake of float_divider.
interface float_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        exception;
  logic        overflow;
  logic        underflow;
  logic        divide_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, result,
    input  exception, overflow, underflow, divide_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, result,
    output exception, overflow, underflow, divide_by_zero
  );
endinterface

// File: rtl/mantissa_divider.sv
// Radix-2 restoring mantissa divider, one quotient bit per step.
module mantissa_divider
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic [REM_W-1:0]  q,
  output logic [REM_W-1:0]  rem
);
  logic [MANT_W-1:0] div;
  logic [REM_W-1:0]  r;
  logic [REM_W-1:0]  diff;
  logic              ge;

  assign ge   = r >= {2'b00, div};
  assign diff = r - {2'b00, div};
  assign rem  = r;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r   <= '0;
      div <= '0;
      q   <= '0;
    end else if (load) begin
      r   <= {2'b00, ma};
      div <= mb;
      q   <= '0;
    end else if (step) begin
      r <= (ge ? diff : r) << 1;
      q <= {q[REM_W-2:0], ge};
    end
  end
endmodule

// File: rtl/float_divider.sv
// Sequential fp32 divider a / b; FP_DIV_ROUND_EN selects round-to-nearest-even.
module float_divider
  import fp32_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  float_divider_if.slave bus
);
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'(2**EXP_W - 1);
  localparam logic signed [EXP_W+1:0] E_ZERO = '0;

  state_t            state, next;
  logic [CNT_W-1:0]  cnt;
  logic              sign, exc, a_zero, b_zero;
  logic [EXP_W-1:0]  ea, eb;
  logic [REM_W-1:0]  q, rem;
  logic              accept, exc_in, az_in, bz_in, special_in;

  assign exc_in = bus.a[FRAC_W +: EXP_W] == EXP_ALL_ONES
               || bus.b[FRAC_W +: EXP_W] == EXP_ALL_ONES;
  assign az_in = bus.a[FRAC_W +: EXP_W] == '0;
  assign bz_in = bus.b[FRAC_W +: EXP_W] == '0;
  assign special_in = exc_in | az_in | bz_in;
  assign accept = bus.start && (state == IDLE || state == DONE);

  mantissa_divider u_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (state == DIVIDE),
    .ma    ({1'b1, bus.a[FRAC_W-1:0]}),
    .mb    ({1'b1, bus.b[FRAC_W-1:0]}),
    .q     (q),
    .rem   (rem)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE:
        next = bus.start ? (special_in ? PACK : DIVIDE) : IDLE;
      DIVIDE:
        if (cnt == CNT_W'(ITERS - 1)) next = PACK;
      PACK:
        next = DONE;
      default:
        next = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      sign   <= 1'b0;
      exc    <= 1'b0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
      ea     <= '0;
      eb     <= '0;
    end else if (accept) begin
      cnt    <= '0;
      sign   <= ~exc_in & (bus.a[31] ^ bus.b[31]);
      exc    <= exc_in;
      a_zero <= az_in;
      b_zero <= bz_in;
      ea     <= bus.a[FRAC_W +: EXP_W];
      eb     <= bus.b[FRAC_W +: EXP_W];
    end else if (state == DIVIDE) begin
      cnt <= cnt + 1'b1;
    end
  end

  logic signed [EXP_W+1:0] e;
  logic [FRAC_W-1:0]       frac;
  logic                    guard, sticky;
  logic                    ovf, unf;
  logic [31:0]             res;

  always_comb begin
    e = {2'b00, ea} - {2'b00, eb} + (EXP_W+2)'(BIAS);
    if (q[REM_W-1]) begin
      frac   = q[REM_W-2:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
    end else begin
      frac   = q[REM_W-3:1];
      guard  = q[0];
      sticky = |rem;
      e      = e - 1'b1;
    end
`ifdef FP_DIV_ROUND_EN
    if (guard & (sticky | frac[0])) begin
      frac = frac + 1'b1;
      // all-ones fraction wraps to zero: mantissa carried into exponent
      if (frac == '0) e = e + 1'b1;
    end
`endif
    ovf = e >= E_MAX;
    unf = e <= E_ZERO;
    if (exc)         res = '0;
    else if (a_zero) res = {sign, 31'd0};
    else if (b_zero) res = {sign, EXP_ALL_ONES, {FRAC_W{1'b0}}};
    else if (ovf)    res = {sign, EXP_ALL_ONES, {FRAC_W{1'b0}}};
    else if (unf)    res = {sign, 31'd0};
    else             res = {sign, e[EXP_W-1:0], frac};
  end

`ifndef FP_DIV_ROUND_EN
  logic unused_gs;
  assign unused_gs = guard ^ sticky;
`endif

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.result         <= '0;
      bus.exception      <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.underflow      <= 1'b0;
      bus.divide_by_zero <= 1'b0;
    end else if (accept) begin
      bus.busy           <= 1'b1;
      bus.done           <= 1'b0;
      bus.result         <= '0;
      bus.exception      <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.underflow      <= 1'b0;
      bus.divide_by_zero <= 1'b0;
    end else if (state == PACK) begin
      bus.busy           <= 1'b0;
      bus.done           <= 1'b1;
      bus.result         <= res;
      bus.exception      <= exc;
      bus.overflow       <= ~(exc | a_zero | b_zero) & ovf;
      bus.underflow      <= ~(exc | a_zero | b_zero) & ~ovf & unf;
      bus.divide_by_zero <= ~exc & ~a_zero & b_zero;
    end else if (state == DONE) begin
      bus.done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed cases plus random ops vs a model.
module tb_float_divider;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail = 0;

  float_divider_if bus();

  float_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, bus.exception, bus.overflow, bus.underflow,
            bus.divide_by_zero};
  endfunction

  // Quotient from integer division; flags as {exc, ovf, unf, dbz}.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [31:0] fl,
                       output int lat);
    int ea, eb, e;
    bit s;
    longint unsigned ma, mb, num, qt, rm, frac;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s = x[31] ^ y[31];
    fl = 0;
    lat = 2;
    if (ea == 255 || eb == 255) begin
      r = 0;
      fl = 32'b1000;
    end else if (ea == 0) begin
      r = {s, 31'd0};
    end else if (eb == 0) begin
      r = {s, 8'hFF, 23'd0};
      fl = 32'b0001;
    end else begin
      lat = 28;
      ma = 64'({1'b1, x[22:0]});
      mb = 64'({1'b1, y[22:0]});
      num = ma << 25;
      qt = num / mb;
      rm = num % mb;
      e = ea - eb + 127;
      if (qt >= (64'd1 << 25)) frac = (qt >> 2) & 64'h7FFFFF;
      else begin
        frac = (qt >> 1) & 64'h7FFFFF;
        e = e - 1;
      end
`ifdef FP_DIV_ROUND_EN
      begin
        bit g, st;
        if (qt >= (64'd1 << 25)) begin
          g = qt[1];
          st = qt[0] || rm != 0;
        end else begin
          g = qt[0];
          st = rm != 0;
        end
        if (g && (st || frac[0])) begin
          frac = frac + 1;
          if (frac == (64'd1 << 23)) begin
            frac = 0;
            e = e + 1;
          end
        end
      end
`else
      if (rm == 64'hFFFF_FFFF_FFFF_FFFF) e = 0;
`endif
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        fl = 32'b0100;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        fl = 32'b0010;
      end else begin
        r = {s, 8'(e), 23'(frac)};
      end
    end
  endtask

  // lat counts falling edges from the sampling edge of start to done high.
  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     input bit b2b, output int lat);
    if (!b2b) @(posedge clk);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    lat = 1;
    @(posedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 64) begin
      @(negedge clk);
      lat++;
      @(posedge clk);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] x,
                    input logic [31:0] y, input bit b2b);
    logic [31:0] er, ef;
    int el, lat;
    model(x, y, er, ef, el);
    run(x, y, b2b, lat);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, flags(), ef);
    check({tag, " latency"}, 32'(lat), 32'(el));
  endtask

  task automatic directed(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er,
                          input logic [31:0] ef, input int el);
    int lat;
    run(x, y, 1'b0, lat);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, flags(), ef);
    check({tag, " latency"}, 32'(lat), 32'(el));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [31:0] x, y;
    logic [31:0] third;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset result", bus.result, 0);
    check("reset flags", flags(), 0);
    reset = 1'b1;

`ifdef FP_DIV_ROUND_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif
    directed("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 28);
    directed("1/3", 32'h3F800000, 32'h40400000, third, 0, 28);
    directed("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 32'b0001, 2);
    directed("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 32'b0100, 28);
    directed("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 32'b0010, 28);
    directed("nan", 32'h7FC00000, 32'h3F800000, 32'h00000000, 32'b1000, 2);
    directed("-6/2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 28);

    // start pulsed while busy must not restart the operation
    @(posedge clk);
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    bus.start = 1'b1;
    @(negedge clk);
    lat = 1;
    @(posedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      lat++;
      @(posedge clk);
    end
    check("busy mid-op", 32'(bus.busy), 1);
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    lat++;
    @(posedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 64) begin
      @(negedge clk);
      lat++;
      @(posedge clk);
    end
    check("ignored start result", bus.result, 32'h40400000);
    check("ignored start latency", 32'(lat), 28);

    // back-to-back start during DONE
    op("b2b", 32'h3F800000, 32'h40400000, 1'b1);

    // reset in the middle of DIVIDE
    @(posedge clk);
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    bus.start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    check("pre-reset busy", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("mid reset busy", 32'(bus.busy), 0);
    check("mid reset done", 32'(bus.done), 0);
    check("mid reset result", bus.result, 0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      seen |= bus.done;
    end
    check("no done in reset", 32'(seen), 0);
    reset = 1'b1;
    directed("post-reset 6/2", 32'h40C00000, 32'h40000000,
             32'h40400000, 0, 28);

    for (int i = 0; i < 150; i++) begin
      int k;
      x = $urandom;
      y = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) x[30:23] = 8'h00;
      if (k == 1) y[30:23] = 8'h00;
      if (k == 2) x[30:23] = 8'hFF;
      if (k == 3) y[30:23] = 8'hFF;
      if (k >= 8) begin
        x[30:23] = 8'($urandom_range(100, 150));
        y[30:23] = 8'($urandom_range(100, 150));
      end
      op($sformatf("rnd%0d", i), x, y, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
